// File: rtl/videosync_pkg.sv
// ============================================================================
// videosync_pkg : shared widths, blanking code and phase decode for videosync
// Revision 1.0
// ============================================================================
`default_nettype none

package videosync_pkg;

  localparam int POS_W   = 10;
  localparam int PORCH_W = 8;
  localparam int CNT_W   = 11;
  localparam logic [POS_W-1:0] BLANK_POS = 10'h3FF;

  typedef enum logic [1:0] {
    PH_VIS  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_t;

  // Zero-width phases fall through naturally because their ranges are empty.
  function automatic phase_t phase_of(
    input logic [CNT_W-1:0]   cnt,
    input logic [POS_W-1:0]   vis,
    input logic [PORCH_W-1:0] fp,
    input logic [PORCH_W-1:0] sp
  );
    logic [CNT_W-1:0] fp_end;
    logic [CNT_W-1:0] sp_end;
    fp_end = CNT_W'(vis) + CNT_W'(fp);
    sp_end = fp_end + CNT_W'(sp);
    if (cnt < CNT_W'(vis))   return PH_VIS;
    else if (cnt < fp_end)   return PH_FP;
    else if (cnt < sp_end)   return PH_SYNC;
    else                     return PH_BP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/videosync_axis.sv
// ============================================================================
// videosync_axis : one timing dimension (counter, totals, phase, position, sync)
// Revision 1.0
// ============================================================================
`default_nettype none

module videosync_axis
  import videosync_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               adv,
  input  logic               load,
  input  logic [POS_W-1:0]   vis_len,
  input  logic [PORCH_W-1:0] fp_len,
  input  logic [PORCH_W-1:0] sp_len,
  input  logic [PORCH_W-1:0] bp_len,
  output logic               wrap,
  output logic [POS_W-1:0]   pos,
  output logic               sync_n
);

  logic [POS_W-1:0]   s_vis;
  logic [PORCH_W-1:0] s_fp;
  logic [PORCH_W-1:0] s_sp;
  logic [PORCH_W-1:0] s_bp;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [CNT_W-1:0]   tot;
  logic               at_end;
  logic [POS_W-1:0]   e_vis;
  logic [PORCH_W-1:0] e_fp;
  logic [PORCH_W-1:0] e_sp;
  phase_t             ph_next;

  // Shadows follow the inputs throughout reset and refresh only at frame start.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      s_vis <= vis_len;
      s_fp  <= fp_len;
      s_sp  <= sp_len;
      s_bp  <= bp_len;
    end
  end

  always_comb begin
    tot      = CNT_W'(s_vis) + CNT_W'(s_fp) + CNT_W'(s_sp) + CNT_W'(s_bp);
    at_end   = (cnt == tot - CNT_W'(1));
    wrap     = adv && at_end;
    cnt_next = cnt;
    if (adv) cnt_next = at_end ? '0 : cnt + CNT_W'(1);
    // On the frame-start edge the outputs already belong to the new timing.
    e_vis    = load ? vis_len : s_vis;
    e_fp     = load ? fp_len  : s_fp;
    e_sp     = load ? sp_len  : s_sp;
    ph_next  = phase_of(cnt_next, e_vis, e_fp, e_sp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      pos    <= '0;
      sync_n <= 1'b1;
    end else begin
      cnt    <= cnt_next;
      pos    <= (ph_next == PH_VIS) ? cnt_next[POS_W-1:0] : BLANK_POS;
      sync_n <= (ph_next != PH_SYNC);
    end
  end

endmodule

`default_nettype wire

// File: rtl/videosync.sv
// ============================================================================
// videosync : raster timing generator with per-frame shadowed timing inputs
// Revision 1.0
// ============================================================================
`default_nettype none

module videosync
  import videosync_pkg::*;
(
  input  logic               pixclk,
  input  logic               rst,
  input  logic [POS_W-1:0]   hv,
  input  logic [PORCH_W-1:0] hfp,
  input  logic [PORCH_W-1:0] hsp,
  input  logic [PORCH_W-1:0] hbp,
  input  logic [POS_W-1:0]   vv,
  input  logic [PORCH_W-1:0] vfp,
  input  logic [PORCH_W-1:0] vsp,
  input  logic [PORCH_W-1:0] vbp,
  output logic [POS_W-1:0]   xpos,
  output logic [POS_W-1:0]   ypos,
  output logic               hs,
  output logic               vs
);

  logic h_wrap;
  logic frame_start;

  // The vertical wrap only fires on a horizontal wrap, so it marks frame start.
  videosync_axis u_h (
    .clk     (pixclk),
    .rst     (rst),
    .adv     (1'b1),
    .load    (frame_start),
    .vis_len (hv),
    .fp_len  (hfp),
    .sp_len  (hsp),
    .bp_len  (hbp),
    .wrap    (h_wrap),
    .pos     (xpos),
    .sync_n  (hs)
  );

  videosync_axis u_v (
    .clk     (pixclk),
    .rst     (rst),
    .adv     (h_wrap),
    .load    (frame_start),
    .vis_len (vv),
    .fp_len  (vfp),
    .sp_len  (vsp),
    .bp_len  (vbp),
    .wrap    (frame_start),
    .pos     (ypos),
    .sync_n  (vs)
  );

endmodule

`default_nettype wire

// File: tb/tb_videosync.sv
// ============================================================================
// tb_videosync : directed self-checking bench for videosync
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_videosync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hv, vv;
  logic [7:0] hfp, hsp, hbp, vfp, vsp, vbp;
  logic [9:0] xpos, ypos;
  logic       hs, vs;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [9:0] xtab [8] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
  logic       hstab[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [9:0] ytab [5] = '{10'd0, 10'd1, 10'h3FF, 10'h3FF, 10'h3FF};
  logic       vstab[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  videosync dut (
    .pixclk (clk),
    .rst    (rst),
    .hv     (hv),
    .hfp    (hfp),
    .hsp    (hsp),
    .hbp    (hbp),
    .vv     (vv),
    .vfp    (vfp),
    .vsp    (vsp),
    .vbp    (vbp),
    .xpos   (xpos),
    .ypos   (ypos),
    .hs     (hs),
    .vs     (vs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_xpos", 32'(xpos), 32'd0);
    check("rst_ypos", 32'(ypos), 32'd0);
    check("rst_hs",   32'(hs),   32'd1);
    check("rst_vs",   32'(vs),   32'd1);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic set_h(input int v_, input int fp, input int sp, input int bp);
    hv = 10'(v_); hfp = 8'(fp); hsp = 8'(sp); hbp = 8'(bp);
  endtask

  task automatic set_v(input int v_, input int fp, input int sp, input int bp);
    vv = 10'(v_); vfp = 8'(fp); vsp = 8'(sp); vbp = 8'(bp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs_low, vs_low;

    // Small line: Htot=8, Vtot=5, two full frames.
    set_h(4, 1, 2, 1);
    set_v(2, 1, 1, 1);
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      tick();
      check("small_xpos", 32'(xpos), 32'(xtab[k % 8]));
      check("small_hs",   32'(hs),   32'(hstab[k % 8]));
      check("small_ypos", 32'(ypos), 32'(ytab[(k / 8) % 5]));
      check("small_vs",   32'(vs),   32'(vstab[(k / 8) % 5]));
    end

    // Mid-frame HV change: old HV holds until frame start at cycle 40.
    do_reset();
    run_to(10);
    hv = 10'd6;
    run_to(12); check("hvchg_old_blank", 32'(xpos), 32'h3FF);
    run_to(40); check("hvchg_fs_xpos",   32'(xpos), 32'd0);
    run_to(44); check("hvchg_new_x4",    32'(xpos), 32'd4);
    run_to(45); check("hvchg_new_x5",    32'(xpos), 32'd5);
    run_to(46); check("hvchg_new_blank", 32'(xpos), 32'h3FF);
    run_to(47); check("hvchg_hs_low",    32'(hs),   32'd0);
    run_to(49); check("hvchg_hs_bp",     32'(hs),   32'd1);
    run_to(50); check("hvchg_wrap10",    32'(xpos), 32'd0);

    // VGA horizontal timing (Htot=832) with a short 6-line frame.
    set_h(640, 24, 40, 128);
    set_v(2, 1, 2, 1);
    do_reset();
    run_to(639);  check("vga_x639",      32'(xpos), 32'd639);
    run_to(640);  check("vga_x640",      32'(xpos), 32'h3FF);
    run_to(663);  check("vga_hs663",     32'(hs),   32'd1);
    run_to(664);  check("vga_hs664",     32'(hs),   32'd0);
    run_to(703);  check("vga_hs703",     32'(hs),   32'd0);
    run_to(704);  check("vga_hs704",     32'(hs),   32'd1);
    run_to(832);  check("vga_line1_x",   32'(xpos), 32'd0);
                  check("vga_line1_y",   32'(ypos), 32'd1);
    run_to(2495); check("vga_vs_before", 32'(vs),   32'd1);
    run_to(2496); check("vga_vs_start",  32'(vs),   32'd0);
                  check("vga_y_blank",   32'(ypos), 32'h3FF);
    run_to(4160); check("vga_vs_end",    32'(vs),   32'd1);
    run_to(4991); check("vga_last_x",    32'(xpos), 32'h3FF);
                  check("vga_last_y",    32'(ypos), 32'h3FF);
    run_to(4992); check("vga_wrap_x",    32'(xpos), 32'd0);
                  check("vga_wrap_y",    32'(ypos), 32'd0);
                  check("vga_wrap_hs",   32'(hs),   32'd1);
                  check("vga_wrap_vs",   32'(vs),   32'd1);

    // Mid-frame reset at h=700, v=3 where both syncs are low.
    run_to(4992 + 3196);
    check("mrst_pre_hs", 32'(hs), 32'd0);
    check("mrst_pre_vs", 32'(vs), 32'd0);
    rst = 1'b1;
    #1;
    check("mrst_hs",   32'(hs),   32'd1);
    check("mrst_vs",   32'(vs),   32'd1);
    check("mrst_xpos", 32'(xpos), 32'd0);
    check("mrst_ypos", 32'(ypos), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("mrst_count", 32'(xpos), 32'(k));
      check("mrst_y0",    32'(ypos), 32'd0);
    end

    // No sync pulses: Htot=792, Vtot=4.
    set_h(640, 24, 0, 128);
    set_v(2, 1, 0, 1);
    do_reset();
    hs_low = 0;
    vs_low = 0;
    for (int k = 1; k <= 3168; k++) begin
      tick();
      if (!hs) hs_low++;
      if (!vs) vs_low++;
      if (k == 791) check("nosync_x791", 32'(xpos), 32'h3FF);
      if (k == 792) check("nosync_x792", 32'(xpos), 32'd0);
    end
    check("nosync_hs_low", 32'(hs_low), 32'd0);
    check("nosync_vs_low", 32'(vs_low), 32'd0);
    check("nosync_frame_y", 32'(ypos), 32'd0);
    check("nosync_frame_x", 32'(xpos), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/videosync.md
VIDEOSYNC -- requirements
Module: videosync

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; there are no parameters, and all timing comes from input ports.
REQ-002 PIXCLK  in  1  pixel clock; all state changes on its rising edge.
REQ-003 RST  in  1  asynchronous active-high reset.
REQ-004 HV  in  10  visible pixels per line.
REQ-005 HFP, HSP, HBP  in  8 each  horizontal front porch, sync pulse and back porch widths, in pixels.
REQ-006 VV  in  10  visible lines per frame.
REQ-007 VFP, VSP, VBP  in  8 each  vertical front porch, sync pulse and back porch widths, in lines.
REQ-008 XPOS  out  10  current visible column, or 10'h3FF when not in a visible column.
REQ-009 YPOS  out  10  current visible line, or 10'h3FF when not in a visible line.
REQ-010 HS, VS  out  1 each  horizontal and vertical sync, active low.

Function
REQ-011 Line total Htot SHALL be HV+HFP+HSP+HBP, computed 11 bits wide; frame total Vtot SHALL be VV+VFP+VSP+VBP, also 11 bits wide.
REQ-012 The 11-bit horizontal counter h SHALL increment every cycle and wrap from Htot-1 to 0.
REQ-013 The 11-bit vertical counter v SHALL increment only on an h wrap, and SHALL wrap from Vtot-1 to 0 on the same edge that h wraps.
REQ-014 Horizontal phase order SHALL be: visible [0,HV), front porch [HV,HV+HFP), sync [HV+HFP,HV+HFP+HSP), back porch to Htot-1.
REQ-015 Vertical phase order SHALL match REQ-014, using the V inputs.
REQ-016 XPOS SHALL be h[9:0] when h<HV, else 10'h3FF; this holds independently of vertical phase.
REQ-017 YPOS SHALL be v[9:0] when v<VV, else 10'h3FF; this holds independently of horizontal phase.
REQ-018 HS SHALL be 0 exactly while h is in the horizontal sync phase, else 1; VS SHALL follow the same rule against v.
REQ-019 A zero-width porch or sync SHALL simply omit that phase; HSP=0 or VSP=0 means no sync pulse is generated.
REQ-020 All outputs SHALL be registered and cycle-aligned with the counters: on the k-th rising edge after reset release, h = k mod Htot.
REQ-021 Timing inputs SHALL be captured into shadow registers while RST is high and at each frame start (h and v both wrapping to 0); mid-frame input changes take effect only at the next frame.
REQ-022 HV and VV SHALL be at least 1 and at most 1023; the caller guarantees this, and behaviour outside that range is unspecified.

Reset
REQ-023 While RST is high: h=0, v=0, XPOS=0, YPOS=0, HS=1, VS=1, and the shadow registers track the inputs.
REQ-024 Reset asserted mid-frame SHALL immediately force the REQ-023 state; counting SHALL resume from (0,0) on the first edge after release.

Structure
REQ-025 Shared package videosync_pkg SHALL hold: POS_W=10, PORCH_W=8, CNT_W=11, BLANK_POS=10'h3FF.
REQ-026 Sub-module videosync_axis SHALL implement one dimension: counter, totals, phase decode, position/blank and sync.
REQ-027 videosync SHALL instantiate videosync_axis twice, with the horizontal wrap serving as the vertical advance enable.

Verification
REQ-028 Small line: HV=4, HFP=1, HSP=2, HBP=1, VV=2, VFP=VSP=VBP=1 -> XPOS sequence 0,1,2,3,3FF,3FF,3FF,3FF repeating; HS low at h=5,6; 5-line frame; VS low on v=3 only.
REQ-029 VGA: 640/24/40/128 and 480/9/3/28 -> Htot=832; HS low h=664..703; Vtot=520; VS low v=489..491; frame period 432640 cycles.
REQ-030 Wrap check -> at h=831, v=519, the next edge gives h=0, v=0, XPOS=0, YPOS=0.
REQ-031 HSP=0 -> HS constant 1 and Htot reduced by 40; VSP=0 -> VS constant 1.
REQ-032 Change HV mid-frame -> current frame keeps the old HV; the new HV applies from the next frame start.
REQ-033 Assert RST at h=700, v=490 (HS=0, VS=0) -> HS=VS=1 and XPOS=YPOS=0 immediately; after release, h counts 0,1,2...
